// File: rtl/sin_dds_gen.sv
// DDS waveform generator: phase accumulator, quarter-wave sine ROM with folding, sine/cosine/square/triangle and amplitude scaling.
// Latency: 3 clk from the accepted-tick edge to out_valid; one sample per clk with back-to-back ticks.
// Backpressure: none; ticks are ignored while enable is low, and in-flight samples always drain.
module sin_dds_gen #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 8,
  parameter int OUT_W   = 16,
  parameter int AMP_W   = 8
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    enable,
  input  logic                    sample_tick,
  input  logic                    phase_clr,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic [1:0]              mode,
  input  logic [AMP_W-1:0]        amp,
  output logic signed [OUT_W-1:0] wave_out,
  output logic                    out_valid,
  output logic                    phase_wrap
);

  localparam int M  = 1 << ADDR_W;
  localparam int QN = M / 4;
  localparam int KW = ADDR_W - 2;
  // Triangle slope: a quarter period of k maps onto the full output range.
  localparam int SH = OUT_W - 1 - KW;

  localparam logic [OUT_W-2:0]  FS_MAG = '1;
  localparam logic [ADDR_W-1:0] QN_I   = ADDR_W'(QN);
  localparam logic [KW:0]       QN_K   = (KW+1)'(QN);
  localparam logic [AMP_W-1:0]  U_A    = {1'b1, {(AMP_W-1){1'b0}}};

  typedef logic [OUT_W-2:0] tab_t [0:QN];

  // Quarter-wave table, evaluated once at elaboration; tab[QN] is exactly full scale.
  function automatic tab_t build_tab();
    tab_t t;
    real  pi;
    pi = 3.14159265358979323846;
    for (int j = 0; j <= QN; j++) begin
      t[j] = (OUT_W-1)'($rtoi(real'(FS_MAG) * $sin(2.0 * pi * j / M) + 0.5));
    end
    return t;
  endfunction

  localparam tab_t TAB = build_tab();

  // ---------------- phase accumulator / stage 1 inputs ----------------
  logic [PHASE_W-1:0] acc;
  logic               accept;
  logic [PHASE_W-1:0] p;
  logic [PHASE_W:0]   sum;
  logic [ADDR_W-1:0]  idx_nxt;

  assign accept  = enable & sample_tick;
  assign p       = phase_clr ? '0 : acc;
  assign sum     = {1'b0, p} + {1'b0, freq_word};
  // Cosine is sine read a quarter period ahead.
  assign idx_nxt = p[PHASE_W-1 -: ADDR_W] + ((mode == 2'd1) ? QN_I : '0);

  // Advance the phase on an accepted tick; a bare phase_clr just zeroes it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc <= '0;
    end else if (accept) begin
      acc <= sum[PHASE_W-1:0];
    end else if (phase_clr) begin
      acc <= '0;
    end
  end

  logic              s1_vld;
  logic [ADDR_W-1:0] s1_idx;
  logic [1:0]        s1_mode;
  logic [AMP_W-1:0]  s1_amp;
  logic              s1_wrap;

  // Stage 1: capture table index and per-sample controls on the accepted tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_vld  <= 1'b0;
      s1_idx  <= '0;
      s1_mode <= '0;
      s1_amp  <= '0;
      s1_wrap <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_idx  <= idx_nxt;
        s1_mode <= mode;
        s1_amp  <= amp;
        s1_wrap <= sum[PHASE_W];
      end
    end
  end

  // ---------------- stage 2: fold quadrant into magnitude and sign ----------------
  logic [1:0]              q;
  logic [KW-1:0]           k;
  logic [KW:0]             k_eff;
  logic [OUT_W:0]          tri_raw;
  logic [OUT_W-2:0]        mag;
  logic signed [OUT_W-1:0] val;

  assign q       = s1_idx[ADDR_W-1 -: 2];
  assign k       = s1_idx[KW-1:0];
  // Odd quadrants run the quarter wave backwards.
  assign k_eff   = q[0] ? (QN_K - {1'b0, k}) : {1'b0, k};
  assign tri_raw = {{(OUT_W-KW){1'b0}}, k_eff} << SH;

  // Select magnitude per waveform; the triangle peak saturates one LSB below 2^(OUT_W-1).
  always_comb begin
    mag = '0;
    case (s1_mode)
      2'd0, 2'd1: mag = TAB[k_eff];
      2'd2:       mag = FS_MAG;
      default:    mag = (tri_raw > {2'b00, FS_MAG}) ? FS_MAG : tri_raw[OUT_W-2:0];
    endcase
    val = q[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

  logic                    s2_vld;
  logic signed [OUT_W-1:0] s2_val;
  logic [AMP_W-1:0]        s2_amp;
  logic                    s2_wrap;

  // Stage 2 registers: signed sample plus the amplitude and wrap flag travelling with it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s2_vld  <= 1'b0;
      s2_val  <= '0;
      s2_amp  <= '0;
      s2_wrap <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_val  <= val;
        s2_amp  <= s1_amp;
        s2_wrap <= s1_wrap;
      end
    end
  end

  // ---------------- stage 3: amplitude scaling ----------------
  logic [AMP_W-1:0]              amp_c;
  logic signed [OUT_W+AMP_W:0]   prod;
  logic signed [OUT_W-1:0]       wave_nxt;

  assign amp_c    = (s2_amp > U_A) ? U_A : s2_amp;
  assign prod     = $signed({{(AMP_W+1){s2_val[OUT_W-1]}}, s2_val})
                  * $signed({{(OUT_W+1){1'b0}}, amp_c});
  // Arithmetic shift floors toward -inf; |val| <= FS and amp_c <= U keep the result in range.
  assign wave_nxt = OUT_W'(prod >>> (AMP_W-1));

  // Output registers; wave_out holds the last sample between valids.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wave_out   <= '0;
      out_valid  <= 1'b0;
      phase_wrap <= 1'b0;
    end else begin
      out_valid  <= s2_vld;
      phase_wrap <= s2_vld & s2_wrap;
      if (s2_vld) begin
        wave_out <= wave_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sin_dds_gen.sv
// Directed bench for sin_dds_gen: reset, latency, all waveforms, amplitude, phase control, reset mid-flight.
// Samples are collected on the falling edge and compared with hand-computed values.
// Inputs are driven on the falling edge; every wait is bounded.
module tb_sin_dds_gen;

  logic               clk = 1'b0;
  logic               resetN;
  logic               enable;
  logic               sample_tick;
  logic               phase_clr;
  logic [15:0]        freq_word;
  logic [1:0]         mode;
  logic [7:0]         amp;
  logic signed [15:0] wave_out;
  logic               out_valid;
  logic               phase_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] q_wave [$];
  logic               q_wrap [$];

  sin_dds_gen #(.PHASE_W(16), .ADDR_W(8), .OUT_W(16), .AMP_W(8)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .enable      (enable),
    .sample_tick (sample_tick),
    .phase_clr   (phase_clr),
    .freq_word   (freq_word),
    .mode        (mode),
    .amp         (amp),
    .wave_out    (wave_out),
    .out_valid   (out_valid),
    .phase_wrap  (phase_wrap)
  );

  always #5 clk = ~clk;

  // Record every produced sample, sampled away from the rising edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q_wave.push_back(wave_out);
      q_wrap.push_back(phase_wrap);
    end
  end

  function automatic logic signed [15:0] wv(int i);
    if (i < q_wave.size()) return q_wave[i];
    return 'x;
  endfunction

  task automatic clear_q();
    q_wave.delete();
    q_wrap.delete();
  endtask

  // Drive n back-to-back ticks (phase_clr on the first if asked), then let the pipe drain.
  task automatic run_ticks(input int n, input logic clr_first);
    for (int i = 0; i < n; i++) begin
      sample_tick = 1'b1;
      phase_clr   = clr_first && (i == 0);
      @(negedge clk);
    end
    sample_tick = 1'b0;
    phase_clr   = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    resetN = 1'b1; enable = 1'b1; sample_tick = 1'b0; phase_clr = 1'b0;
    freq_word = 16'h0000; mode = 2'd0; amp = 8'd128;
    #3 resetN = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (wave_out !== 16'sd0) begin n_fail++; $display("FAIL reset_wave_out got=%0d exp=0", wave_out); end
    n_tests++; if (phase_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_phase_wrap got=%b exp=0", phase_wrap); end
    resetN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sine_stream();
    int lat;
    int ticks;
    int errs;
    freq_word = 16'h0100; mode = 2'd0; amp = 8'd128;
    clear_q();
    sample_tick = 1'b1;
    lat = 0; ticks = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      ticks++;
      if (out_valid === 1'b1) lat = c;
    end
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL sine_latency got=%0d exp=3", lat); end
    repeat (520 - ticks) @(negedge clk);
    sample_tick = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (q_wave.size() != 520) begin n_fail++; $display("FAIL sine_count got=%0d exp=520", q_wave.size()); end
    n_tests++; if (wv(0) !== 16'sd0) begin n_fail++; $display("FAIL sine_idx0 got=%0d exp=0", wv(0)); end
    n_tests++; if (wv(64) !== 16'sd32767) begin n_fail++; $display("FAIL sine_idx64 got=%0d exp=32767", wv(64)); end
    n_tests++; if (wv(128) !== 16'sd0) begin n_fail++; $display("FAIL sine_idx128 got=%0d exp=0", wv(128)); end
    n_tests++; if (wv(192) !== -16'sd32767) begin n_fail++; $display("FAIL sine_idx192 got=%0d exp=-32767", wv(192)); end
    errs = 0;
    for (int i = 0; i < q_wrap.size(); i++) begin
      if (q_wrap[i] !== ((i % 256) == 255)) errs++;
    end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL sine_wrap_pattern got=%0d wrong samples exp=0", errs); end
  endtask

  task automatic test_cosine();
    mode = 2'd1; freq_word = 16'h0100; amp = 8'd128;
    clear_q();
    run_ticks(65, 1'b1);
    n_tests++; if (wv(0) !== 16'sd32767) begin n_fail++; $display("FAIL cos_idx0 got=%0d exp=32767", wv(0)); end
    n_tests++; if (wv(64) !== 16'sd0) begin n_fail++; $display("FAIL cos_idx64 got=%0d exp=0", wv(64)); end
  endtask

  task automatic test_triangle_square();
    mode = 2'd3; freq_word = 16'h0100; amp = 8'd128;
    clear_q();
    run_ticks(161, 1'b1);
    n_tests++; if (wv(32) !== 16'sd16384) begin n_fail++; $display("FAIL tri_idx32 got=%0d exp=16384", wv(32)); end
    n_tests++; if (wv(64) !== 16'sd32767) begin n_fail++; $display("FAIL tri_idx64 got=%0d exp=32767", wv(64)); end
    n_tests++; if (wv(96) !== 16'sd16384) begin n_fail++; $display("FAIL tri_idx96 got=%0d exp=16384", wv(96)); end
    n_tests++; if (wv(160) !== -16'sd16384) begin n_fail++; $display("FAIL tri_idx160 got=%0d exp=-16384", wv(160)); end
    mode = 2'd2;
    clear_q();
    run_ticks(129, 1'b1);
    n_tests++; if (wv(0) !== 16'sd32767) begin n_fail++; $display("FAIL sq_idx0 got=%0d exp=32767", wv(0)); end
    n_tests++; if (wv(128) !== -16'sd32767) begin n_fail++; $display("FAIL sq_idx128 got=%0d exp=-32767", wv(128)); end
  endtask

  task automatic test_amplitude();
    int wraps;
    mode = 2'd0;
    clear_q();
    sample_tick = 1'b1; phase_clr = 1'b1; freq_word = 16'hC000; amp = 8'd128;
    @(negedge clk);
    phase_clr = 1'b0; freq_word = 16'h0000; amp = 8'd64;
    @(negedge clk);
    amp = 8'd0;
    @(negedge clk);
    amp = 8'd200;
    @(negedge clk);
    amp = 8'd64;
    @(negedge clk);
    sample_tick = 1'b0; amp = 8'd128;
    repeat (5) @(negedge clk);
    n_tests++; if (q_wave.size() != 5) begin n_fail++; $display("FAIL amp_count got=%0d exp=5", q_wave.size()); end
    n_tests++; if (wv(1) !== -16'sd16384) begin n_fail++; $display("FAIL amp_half got=%0d exp=-16384", wv(1)); end
    n_tests++; if (wv(2) !== 16'sd0) begin n_fail++; $display("FAIL amp_zero got=%0d exp=0", wv(2)); end
    n_tests++; if (wv(3) !== -16'sd32767) begin n_fail++; $display("FAIL amp_clamp got=%0d exp=-32767", wv(3)); end
    n_tests++; if (wv(4) !== -16'sd16384) begin n_fail++; $display("FAIL amp_captured got=%0d exp=-16384", wv(4)); end
    wraps = 0;
    for (int i = 0; i < q_wrap.size(); i++) if (q_wrap[i] !== 1'b0) wraps++;
    n_tests++; if (wraps != 0) begin n_fail++; $display("FAIL amp_no_wrap got=%0d exp=0", wraps); end
  endtask

  task automatic test_phase_ctrl();
    // acc is 0xC000 here: the first three ticks read idx 192..194.
    mode = 2'd0; freq_word = 16'h0100; amp = 8'd128;
    clear_q();
    for (int i = 0; i < 5; i++) begin
      sample_tick = 1'b1;
      phase_clr   = (i == 3);
      @(negedge clk);
    end
    sample_tick = 1'b0; phase_clr = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (q_wave.size() != 5) begin n_fail++; $display("FAIL clr_count got=%0d exp=5", q_wave.size()); end
    n_tests++; if (wv(0) !== -16'sd32767) begin n_fail++; $display("FAIL clr_pre_idx192 got=%0d exp=-32767", wv(0)); end
    n_tests++; if (wv(3) !== 16'sd0) begin n_fail++; $display("FAIL clr_idx0 got=%0d exp=0", wv(3)); end
    n_tests++; if (wv(4) !== 16'sd804) begin n_fail++; $display("FAIL clr_idx1 got=%0d exp=804", wv(4)); end
    // enable low: tick pulses must be ignored.
    clear_q();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample_tick = (i % 2 == 0);
      @(negedge clk);
    end
    sample_tick = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (q_wave.size() != 0) begin n_fail++; $display("FAIL disabled_samples got=%0d exp=0", q_wave.size()); end
    enable = 1'b1;
    run_ticks(1, 1'b0);
    n_tests++; if (wv(0) !== 16'sd1608) begin n_fail++; $display("FAIL resume_idx2 got=%0d exp=1608", wv(0)); end
    // phase_clr with no tick: zero the phase, emit nothing.
    clear_q();
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (q_wave.size() != 0) begin n_fail++; $display("FAIL bare_clr_samples got=%0d exp=0", q_wave.size()); end
    run_ticks(2, 1'b0);
    n_tests++; if (wv(0) !== 16'sd0) begin n_fail++; $display("FAIL bare_clr_idx0 got=%0d exp=0", wv(0)); end
    n_tests++; if (wv(1) !== 16'sd804) begin n_fail++; $display("FAIL bare_clr_idx1 got=%0d exp=804", wv(1)); end
  endtask

  task automatic test_reset_inflight();
    mode = 2'd1; freq_word = 16'h4000; amp = 8'd128;
    sample_tick = 1'b1; phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    repeat (2) @(negedge clk);
    sample_tick = 1'b0;
    n_tests++; if (wave_out !== 16'sd32767) begin n_fail++; $display("FAIL inflight_pre got=%0d exp=32767", wave_out); end
    resetN = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_rst_valid got=%b exp=0", out_valid); end
    n_tests++; if (wave_out !== 16'sd0) begin n_fail++; $display("FAIL inflight_rst_wave got=%0d exp=0", wave_out); end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    clear_q();
    repeat (6) @(negedge clk);
    n_tests++; if (q_wave.size() != 0) begin n_fail++; $display("FAIL post_rst_samples got=%0d exp=0", q_wave.size()); end
    mode = 2'd0; freq_word = 16'h0100;
    run_ticks(2, 1'b0);
    n_tests++; if (q_wave.size() != 2) begin n_fail++; $display("FAIL post_rst_count got=%0d exp=2", q_wave.size()); end
    n_tests++; if (wv(0) !== 16'sd0) begin n_fail++; $display("FAIL post_rst_idx0 got=%0d exp=0", wv(0)); end
    n_tests++; if (wv(1) !== 16'sd804) begin n_fail++; $display("FAIL post_rst_idx1 got=%0d exp=804", wv(1)); end
  endtask

  initial begin
    test_reset();
    test_sine_stream();
    test_cosine();
    test_triangle_square();
    test_amplitude();
    test_phase_ctrl();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sin_dds_gen.md
Name: sin_dds_gen

Overview:
Parametrised direct-digital-synthesis waveform generator and successor to the fixed 8-bit sine lookup. It holds a phase accumulator with a programmable frequency word and uses a quarter-wave sine table with symmetry folding. It produces signed sine, cosine, square or triangle samples with amplitude scaling. It feeds the game's audio tone path and oscillating sprite-motion logic, at up to one sample per clk.

Parameters:
- PHASE_W, 16: phase accumulator width.
- ADDR_W, 8: full-period index width. M = 2^ADDR_W points per period; the quarter table holds M/4+1 entries.
- OUT_W, 16: signed output width. Full scale FS = 2^(OUT_W-1)-1.
- AMP_W, 8: amplitude input width. Unity U = 2^(AMP_W-1).

Ports:
- clk, in, 1: clock.
- resetN, in, 1: asynchronous active-low reset.
- enable, in, 1: when low, ticks are ignored and the phase holds.
- sample_tick, in, 1: request one sample and advance the phase.
- phase_clr, in, 1: synchronous phase clear.
- freq_word, in, PHASE_W: phase increment per accepted tick.
- mode, in, 2: 0 sine, 1 cosine, 2 square, 3 triangle.
- amp, in, AMP_W: unsigned amplitude.
- wave_out, out, OUT_W: signed sample.
- out_valid, out, 1: one-cycle pulse per sample.
- phase_wrap, out, 1: aligned with out_valid; high when this sample's phase increment wrapped the accumulator.

Behaviour:
Clocking and reset
- Reset is resetN, asynchronous, active-low; clock is clk.
- In reset, acc, all pipeline registers, wave_out, out_valid and phase_wrap are 0.
- Reset asserted mid-pipeline discards in-flight samples immediately.

Tick acceptance and phase
- A tick is accepted when enable & sample_tick.
- The sample phase P = (phase_clr ? 0 : acc).
- On an accepted tick: acc <= P + freq_word mod 2^PHASE_W. The wrap flag is the carry out of that add.
- phase_clr without an accepted tick: acc <= 0 and no sample is produced.
- freq_word, mode and amp are captured in stage 1 on the accepted tick. In-flight samples are unaffected by later changes.
- enable low: no new samples. Samples already in flight still complete.

Pipeline (3 cycles; out_valid 3 clk after the accepted-tick edge; back-to-back ticks give one sample per cycle)
- S1: idx = P[PHASE_W-1 -: ADDR_W], plus M/4 mod M if mode=1. Split into q = idx[ADDR_W-1:ADDR_W-2] and k = idx[ADDR_W-3:0]. Register idx, q, k, mode, amp and the wrap flag.
- S2: unsigned magnitude mag and sign neg.
  - Table: tab[j] = round(FS*sin(2*pi*j/M)) for j = 0..M/4. It is a constant ROM, read combinationally from registered S1 values.
  - Sine/cosine: q0 mag = tab[k]; q1 mag = tab[M/4-k]; q2 as q0, q3 as q1. neg = q[1].
  - Square: mag = FS, neg = q[1].
  - Triangle: q0/q2 mag = k << (OUT_W-1-(ADDR_W-2)); q1/q3 mag = (M/4-k) << same. Saturate to FS. neg = q[1].
  - val = neg ? -mag : mag, as a signed OUT_W value.
- S3:
  - amp_c = min(amp, U).
  - wave_out <= (val*amp_c) >>> (AMP_W-1). The arithmetic shift floors toward -inf. The product is carried at full width and the result fits OUT_W.
  - out_valid <= S2 valid. phase_wrap <= S2 wrap.
  - wave_out holds its value between samples.

Boundaries
- freq_word = 0: repeated identical samples. No wrap.
- idx = M/4 exactly gives tab[M/4] = FS.
- amp = 0 gives exactly 0.
- amp > U is clamped to unity.

Test Plan:
1. Reset release; freq_word=0x0100, mode=0, amp=128, tick every cycle.
   - First out_valid 3 cycles after the first tick.
   - Samples idx 0, 64, 128, 192 give 0, 32767, 0, -32767.
   - phase_wrap is high only on the idx-255 sample, repeating every 256 samples.
2. mode=1, same stimulus from phase 0 -> first sample 32767; idx 64 sample gives 0.
3. mode=3 -> idx 32 = 16384, idx 64 = 32767 (saturated), idx 96 = 16384, idx 160 = -16384. mode=2 -> idx 0 = 32767, idx 128 = -32767.
4. mode=0, idx 192:
   - amp=64 gives -16384 (floored).
   - amp=0 gives 0.
   - amp=200 gives -32767.
   - Change amp one cycle after the tick: that sample keeps the old amp.
5. Mid-run phase_clr with tick -> that sample is idx 0 (value 0); the next is idx 1. enable low with tick pulses -> no out_valid after 3-cycle drain, acc unchanged. Resumption continues from the held phase.
6. resetN low during 3 in-flight samples -> wave_out=0 and out_valid=0 immediately. No out_valid after release until a new tick; the first sample is idx 0.
